// File: rtl/ks_adder_pipe_pkg.sv
// Elaboration helpers for the Kogge-Stone adder: prefix depth and register stage count.
package ks_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of prefix levels needed to propagate a carry across the whole word.
  function automatic int ks_levels(input int width);
    return clog2(width);
  endfunction

endpackage

// File: rtl/ks_adder_pipe_if.sv
// Operand/result handshake bundle for ks_adder_pipe; master drives operands, slave is the adder.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 25,
  parameter int TAG_W = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_tag
  );
endinterface

// File: rtl/ks_adder_pipe_prefix.sv
// One combinational Kogge-Stone prefix level: combines each bit with the bit DIST below it.
module ks_prefix_level #(
  parameter int WIDTH = 25,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi >= DIST) begin : g_cell
      assign g_o[gi] = g_i[gi] | (p_i[gi] & g_i[gi-DIST]);
      assign p_o[gi] = p_i[gi] & p_i[gi-DIST];
    end else begin : g_pass
      assign g_o[gi] = g_i[gi];
      assign p_o[gi] = p_i[gi];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: PG register, K prefix register stages, output register,
// with a per-stage valid/ready chain so empty stages keep accepting while the output is stalled.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH         = 25,
  parameter int LVL_PER_STAGE = 1,
  parameter int TAG_W         = 1
) (
  input logic            clock,
  input logic            resetn,
  ks_adder_pipe_if.slave bus
);

  localparam int L  = ks_levels(WIDTH);
  localparam int K  = ceil_div(L, LVL_PER_STAGE);
  localparam int NS = K + 2;

  // Index 0 is the PG register, 1..K the prefix registers; the output register is separate.
  logic [WIDTH-1:0] gg_q  [0:K];
  logic [WIDTH-1:0] pp_q  [0:K];
  logic [WIDTH-1:0] p0_q  [0:K];
  logic             c0_q  [0:K];
  logic [TAG_W-1:0] tag_q [0:K];
  logic [WIDTH-1:0] gg_d  [0:K];
  logic [WIDTH-1:0] pp_d  [0:K];
  logic [NS-1:0]    v_q;
  logic [NS-1:0]    rdy;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [TAG_W-1:0] tag_out_q;

  logic [WIDTH-1:0] b_eff;
  logic             c0_d;
  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] sum_d;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0_d  = bus.in_cin ^ bus.in_sub;
  assign p_d   = bus.in_a ^ b_eff;
  // Folding c0 into G[0] makes GG[i] the carry out of bit i after the prefix tree.
  assign g_d   = (bus.in_a & b_eff) | {{(WIDTH-1){1'b0}}, p_d[0] & c0_d};

  assign gg_d[0] = g_d;
  assign pp_d[0] = p_d;

  logic [WIDTH-1:0] lvl_g_in  [0:L-1];
  logic [WIDTH-1:0] lvl_p_in  [0:L-1];
  logic [WIDTH-1:0] lvl_g_out [0:L-1];
  logic [WIDTH-1:0] lvl_p_out [0:L-1];

  for (genvar gi = 0; gi < L; gi++) begin : g_lvl
    localparam int GRP = gi / LVL_PER_STAGE;
    if (gi % LVL_PER_STAGE == 0) begin : g_first
      assign lvl_g_in[gi] = gg_q[GRP];
      assign lvl_p_in[gi] = pp_q[GRP];
    end else begin : g_chain
      assign lvl_g_in[gi] = lvl_g_out[gi-1];
      assign lvl_p_in[gi] = lvl_p_out[gi-1];
    end
    ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << gi)) u_lvl (
      .g_i (lvl_g_in[gi]),
      .p_i (lvl_p_in[gi]),
      .g_o (lvl_g_out[gi]),
      .p_o (lvl_p_out[gi])
    );
  end

  // The last group may hold fewer than LVL_PER_STAGE levels.
  for (genvar gi = 1; gi <= K; gi++) begin : g_stage
    localparam int LAST = ((gi * LVL_PER_STAGE < L) ? gi * LVL_PER_STAGE : L) - 1;
    assign gg_d[gi] = lvl_g_out[LAST];
    assign pp_d[gi] = lvl_p_out[LAST];
  end

  assign sum_d = p0_q[K] ^ {gg_q[K][WIDTH-2:0], c0_q[K]};

  always_comb begin
    logic r;
    rdy = '0;
    r   = bus.out_ready;
    for (int s = NS - 1; s >= 0; s--) begin
      r      = ~v_q[s] | r;
      rdy[s] = r;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      tag_out_q <= '0;
      for (int s = 0; s <= K; s++) begin
        gg_q[s]  <= '0;
        pp_q[s]  <= '0;
        p0_q[s]  <= '0;
        c0_q[s]  <= 1'b0;
        tag_q[s] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        gg_q[0]  <= gg_d[0];
        pp_q[0]  <= pp_d[0];
        p0_q[0]  <= p_d;
        c0_q[0]  <= c0_d;
        tag_q[0] <= bus.in_tag;
        v_q[0]   <= bus.in_valid;
      end
      for (int s = 1; s <= K; s++) begin
        if (rdy[s]) begin
          gg_q[s]  <= gg_d[s];
          pp_q[s]  <= pp_d[s];
          p0_q[s]  <= p0_q[s-1];
          c0_q[s]  <= c0_q[s-1];
          tag_q[s] <= tag_q[s-1];
          v_q[s]   <= v_q[s-1];
        end
      end
      if (rdy[K+1]) begin
        sum_q     <= sum_d;
        cout_q    <= gg_q[K][WIDTH-1];
        tag_out_q <= tag_q[K];
        v_q[K+1]  <= v_q[K];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[K+1];
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_tag   = tag_out_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboarded bench for ks_adder_pipe: a 25-bit one-level-per-stage instance and a 32-bit
// three-levels-per-stage instance, each checked against a plain integer adder model.
module tb_ks_adder_pipe;

  localparam int W   = 25;
  localparam int LPS = 1;
  localparam int NS  = 7;   // 5 prefix levels, 5 register stages, plus PG and output
  localparam int W2  = 32;
  localparam int LPS2 = 3;
  localparam int NS2 = 4;   // 5 levels in groups of 3 -> 2 stages, plus PG and output
  localparam int TW  = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(W),  .TAG_W(TW)) bus ();
  ks_adder_pipe_if #(.WIDTH(W2), .TAG_W(TW)) bus2 ();

  ks_adder_pipe #(.WIDTH(W), .LVL_PER_STAGE(LPS), .TAG_W(TW)) dut (
    .clock(clk), .resetn(resetn), .bus(bus.slave)
  );
  ks_adder_pipe #(.WIDTH(W2), .LVL_PER_STAGE(LPS2), .TAG_W(TW)) dut2 (
    .clock(clk), .resetn(resetn), .bus(bus2.slave)
  );

  int checks = 0;
  int errors = 0;
  int pops1 = 0;
  int pops2 = 0;
  logic [TW+W:0]  q1 [$];
  logic [TW+W2:0] q2 [$];
  logic [TW+W:0]  e1, a1;
  logic [TW+W2:0] e2, a2;

  function automatic logic [63:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] bb;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? (~b & mask) : (b & mask);
    return (a & mask) + bb + {63'd0, cin ^ sub};
  endfunction

  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      checks++;
      pops1++;
      a1 = {bus.out_tag, bus.out_cout, bus.out_sum};
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected got tag=%h cout=%b sum=%h need nothing", bus.out_tag, bus.out_cout, bus.out_sum);
      end else begin
        e1 = q1.pop_front();
        if (a1 !== e1) begin
          errors++;
          $display("FAIL dut1_result got tag=%h cout=%b sum=%h need tag=%h cout=%b sum=%h",
                   a1[TW+W:W+1], a1[W], a1[W-1:0], e1[TW+W:W+1], e1[W], e1[W-1:0]);
        end else begin
          $display("dut1 tag=%h cout=%b sum=%h ok", a1[TW+W:W+1], a1[W], a1[W-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && bus2.out_valid && bus2.out_ready) begin
      checks++;
      pops2++;
      a2 = {bus2.out_tag, bus2.out_cout, bus2.out_sum};
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected got tag=%h cout=%b sum=%h need nothing", bus2.out_tag, bus2.out_cout, bus2.out_sum);
      end else begin
        e2 = q2.pop_front();
        if (a2 !== e2) begin
          errors++;
          $display("FAIL dut2_result got tag=%h cout=%b sum=%h need tag=%h cout=%b sum=%h",
                   a2[TW+W2:W2+1], a2[W2], a2[W2-1:0], e2[TW+W2:W2+1], e2[W2], e2[W2-1:0]);
        end else begin
          $display("dut2 tag=%h cout=%b sum=%h ok", a2[TW+W2:W2+1], a2[W2], a2[W2-1:0]);
        end
      end
    end
  end

  // Records accepted operands into the scoreboards, then advances to just after the next edge.
  task automatic tick();
    logic [63:0] r;
    @(negedge clk);
    if (resetn && bus.in_valid && bus.in_ready) begin
      r = ref_add(W, 64'(bus.in_a), 64'(bus.in_b), bus.in_cin, bus.in_sub);
      q1.push_back({bus.in_tag, r[W:0]});
    end
    if (resetn && bus2.in_valid && bus2.in_ready) begin
      r = ref_add(W2, 64'(bus2.in_a), 64'(bus2.in_b), bus2.in_cin, bus2.in_sub);
      q2.push_back({bus2.in_tag, r[W2:0]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [TW-1:0] tag);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
  endtask

  task automatic drive1_rand(input logic [TW-1:0] tag);
    logic [31:0] ra, rb;
    ra = $urandom();
    rb = $urandom();
    drive1(1'b1, ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && (q1.size() != 0 || q2.size() != 0); i++) tick();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got q1=%0d q2=%0d pending need 0", q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", bus.out_valid); end
    checks++; if (bus.out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %h need 0", bus.out_sum); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b need 0", bus.out_cout); end
    checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %h need 0", bus.out_tag); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b need 1", bus.in_ready); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    int lat;
    drive1(1'b1, 25'h1FFFFFF, 25'h0000001, 1'b0, 1'b0, 3'd5);
    tick();
    lat = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat != NS) begin errors++; $display("FAIL add_latency got %0d need %0d", lat, NS); end
    checks++; if (bus.out_sum !== 25'h0) begin errors++; $display("FAIL add_sum got %h need 0000000", bus.out_sum); end
    checks++; if (bus.out_cout !== 1'b1) begin errors++; $display("FAIL add_cout got %b need 1", bus.out_cout); end
    checks++; if (bus.out_tag !== 3'd5) begin errors++; $display("FAIL add_tag got %h need 5", bus.out_tag); end
    wait_drain();
  endtask

  task automatic test_sub();
    drive1(1'b1, 25'd5, 25'd7, 1'b0, 1'b1, 3'd1); tick();
    drive1(1'b1, 25'd7, 25'd5, 1'b0, 1'b1, 3'd2); tick();
    drive1(1'b1, 25'd5, 25'd3, 1'b1, 1'b1, 3'd3); tick();
    drive1(1'b1, 25'h10, 25'h20, 1'b1, 1'b0, 3'd4); tick();
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_stream();
    int run, best, p0;
    run = 0;
    best = 0;
    p0 = pops1;
    for (int i = 0; i < 20 + 15; i++) begin
      if (i < 20) drive1_rand(TW'(i)); else bus.in_valid = 1'b0;
      tick();
      if (bus.out_valid) begin run++; if (run > best) best = run; end else run = 0;
    end
    wait_drain();
    checks++; if (best != 20) begin errors++; $display("FAIL stream_run got %0d need 20", best); end
    checks++; if (pops1 - p0 != 20) begin errors++; $display("FAIL stream_count got %0d need 20", pops1 - p0); end
  endtask

  task automatic test_backpressure();
    int acc, p0;
    logic [TW+W:0] snap;
    acc = 0;
    p0 = pops1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive1_rand(TW'(i + 1));
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (acc != NS) begin errors++; $display("FAIL bp_accepted got %0d need %0d", acc, NS); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b need 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b need 1", bus.out_valid); end
    snap = {bus.out_tag, bus.out_cout, bus.out_sum};
    repeat (3) tick();
    checks++;
    if ({bus.out_tag, bus.out_cout, bus.out_sum} !== snap) begin
      errors++;
      $display("FAIL bp_stable got %h need %h", {bus.out_tag, bus.out_cout, bus.out_sum}, snap);
    end
    bus.out_ready = 1'b1;
    wait_drain();
    checks++; if (pops1 - p0 != NS) begin errors++; $display("FAIL bp_drained got %0d need %0d", pops1 - p0, NS); end
  endtask

  task automatic test_bubbles();
    int acc, p0;
    acc = 0;
    p0 = pops1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) drive1_rand(TW'(i)); else bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (acc != NS) begin errors++; $display("FAIL bubble_accepted got %0d need %0d", acc, NS); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bubble_in_ready got %b need 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    wait_drain();
    checks++; if (pops1 - p0 != NS) begin errors++; $display("FAIL bubble_drained got %0d need %0d", pops1 - p0, NS); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive1_rand(TW'(i)); tick(); end
    bus.in_valid = 1'b0;
    repeat (8) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_before got %b need 1", bus.out_valid); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b need 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b need 1", bus.in_ready); end
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_stale got %0d results need 0", seen); end
  endtask

  task automatic test_sweep();
    int lat, p0;
    logic [31:0] ra, rb;
    bus2.in_valid = 1'b1; bus2.in_a = 32'hFFFF_FFFF; bus2.in_b = 32'h0000_0002;
    bus2.in_cin = 1'b1; bus2.in_sub = 1'b0; bus2.in_tag = 3'd6;
    tick();
    lat = 1;
    bus2.in_valid = 1'b0;
    while (!bus2.out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat != NS2) begin errors++; $display("FAIL sweep_latency got %0d need %0d", lat, NS2); end
    wait_drain();
    p0 = pops2;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom(); rb = $urandom();
      bus2.in_valid = 1'b1; bus2.in_a = ra; bus2.in_b = rb;
      bus2.in_cin = 1'($urandom_range(0, 1)); bus2.in_sub = 1'($urandom_range(0, 1)); bus2.in_tag = TW'(i);
      tick();
    end
    bus2.in_valid = 1'b0;
    wait_drain();
    checks++; if (pops2 - p0 != 20) begin errors++; $display("FAIL sweep_count got %0d need 20", pops2 - p0); end
  endtask

  initial begin
    drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_a      = '0;
    bus2.in_b      = '0;
    bus2.in_cin    = 1'b0;
    bus2.in_sub    = 1'b0;
    bus2.in_tag    = '0;
    bus2.out_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_sub();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_sweep();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL final_queues got q1=%0d q2=%0d need 0", q1.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a sideband tag carried alongside the data. It is the generalised successor of the fixed 25-bit hand-staged prefix steps used in the FP MAC mantissa path. Width, the number of prefix levels per register stage, and the tag width are all configurable. It supports carry-in, subtraction and backpressure with bubble collapsing.

## Interface
- WIDTH, 25, operand and sum width in bits (>= 2)
- LVL_PER_STAGE, 1, Kogge-Stone prefix levels evaluated between pipeline registers (>= 1)
- TAG_W, 1, sideband width (e.g. sign, exponent flags); passed through unmodified
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept input this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (borrow-in when subtracting)
- in_sub  in  1  1 = subtract (A + ~B + ~cin... see Operation)
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  sum/difference
- out_cout  out  1  carry-out (for subtraction: 1 = no borrow)
- out_tag  out  TAG_W  sideband of the same transaction

## Operation
- Effective operands: B' = in_sub ? ~in_b : in_b; c0 = in_cin ^ in_sub. Result = in_a + B' + c0, mod 2^WIDTH, cout = bit WIDTH.
  - Consequences: sub=0,cin=0 gives A+B; sub=1,cin=0 gives A-B; sub=1,cin=1 gives A-B-1.
- Stage 0 (PG): P[i] = a[i]^B'[i]. G[i] = a[i]&B'[i], except G[0] = a0&B'0 | P0&c0. P vector and c0 are saved for the sum.
- Prefix: L = clog2(WIDTH) levels; level j uses distance 2^j.
  - Bits i >= 2^j: GG[i] = G[i] | P[i]&G[i-2^j]; PP[i] = P[i]&P[i-2^j].
  - Lower bits pass unchanged.
- K = ceil(L / LVL_PER_STAGE) prefix register stages. The final group may contain fewer levels.
- Output stage: sum[0] = P0[0]^c0; sum[i] = P0[i]^GG[i-1]; cout = GG[WIDTH-1].
- Every stage carries valid, the original P vector, c0 and tag.
- Flow control: per-stage valid bit v[s]. ready[s] = !v[s] | ready[s+1]; ready past the output stage = out_ready; in_ready = ready[0].
  - Stage s loads from s-1 when ready[s]; its valid becomes v[s-1] (or in_valid at stage 0).
  - A stalled stage holds its data and valid unchanged.
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Reset (async assert): all v[s]=0 and all data registers 0. So out_valid=0, out_sum=0, out_cout=0, out_tag=0, and in_ready=1 after reset.
- Reset mid-operation drops all in-flight transactions; no partial output is produced.

## Timing
- Latency in_valid&in_ready to out_valid = K+2 cycles with no stall. WIDTH=25, LVL_PER_STAGE=1: L=5, K=5, latency 7. With LVL_PER_STAGE=2: K=3, latency 5.
- Throughput: one transaction per cycle while out_ready=1.
- Outputs are registered. out_sum/out_cout/out_tag stay stable while out_valid=1 and out_ready=0.
- in_ready is combinational from out_ready through the valid chain. This is an accepted ready path of depth K+2.
- Capacity is K+2 transactions. When full and out_ready=0, in_ready=0.
- Simultaneous accept and emit in the same cycle when full is allowed if out_ready=1.

## Structure
- Package ks_pkg: clog2 and ceil_div functions, and a ks_levels(WIDTH) helper. All are used for L and K at elaboration.
- Sub-module ks_prefix_level (params WIDTH, DIST): one combinational prefix level built from G/P cells. It is instantiated L times by generate and grouped between registers.
- Top module: PG stage, generate-built register pipeline, output stage and valid/ready chain.

## Test plan
- Reset, then WIDTH=25, a=0x1FFFFFF, b=0x0000001, cin=0, sub=0 -> 7 cycles later sum=0x0000000, cout=1, out_tag equal to the input tag.
- sub=1, a=0x0000005, b=0x0000007, cin=0 -> sum=0x1FFFFFE, cout=0 (borrow). Repeat with a=7, b=5 -> sum=0x0000002, cout=1.
- Stream 20 random transactions, in_valid and out_ready held at 1 -> one result per cycle, in order, each matching a + B' + c0 and carrying its own tag.
- Hold out_ready=0 while feeding -> exactly K+2 transactions accepted, then in_ready=0 and output stable. Release -> all results drained in order with none lost or duplicated.
- Insert bubbles (in_valid toggling) with out_ready=0 -> bubbles collapse, so stored count equals K+2 before in_ready drops.
- Assert resetn low with 3 transactions in flight -> out_valid=0 immediately and no stale result appears after release. Also sweep LVL_PER_STAGE in {1,2,3} and WIDTH in {8,25,32} against a reference adder model.
